// File: rtl/huffman_stream_ctrl.sv
// huffman_stream_ctrl: sequences one Huffman weight-decompression job.
// Fetches compressed words from D_xmem, offers them to the decoder over
// valid/ready, packs decoded 4-bit symbols eight per 32-bit word, writes the
// packed words to the staging SRAM and reports done (with err on stall).
module huffman_stream_ctrl #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [CNT_W-1:0]  num_symbols,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_cen,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_q,
    output logic [31:0]       dec_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    input  logic [3:0]        dec_sym,
    input  logic              dec_sym_valid,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data
);

    localparam int unsigned TO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OFFER,
        S_DRAIN,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] num_words_q, num_words_d;
    logic [CNT_W-1:0]  num_symbols_q, num_symbols_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  taken_q, taken_d;
    logic [ADDR_W-1:0] written_q, written_d;
    logic [31:0]       pack_q, pack_d;
    logic [TO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_cen_q, mem_cen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       dec_data_q, dec_data_d;
    logic              dec_valid_q, dec_valid_d;
    logic              out_wen_q, out_wen_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_data_q, out_data_d;

    logic [31:0]       pack_ins;
    logic              capture;

    // Next-state, symbol packing and registered-output computation.
    // Outputs are derived from state_d so they are valid during the state
    // itself; the FLUSH write is issued on entry so done follows it by one cycle.
    always_comb begin
        state_d       = state_q;
        rd_base_d     = rd_base_q;
        num_words_d   = num_words_q;
        num_symbols_d = num_symbols_q;
        wr_base_d     = wr_base_q;
        word_idx_d    = word_idx_q;
        taken_d       = taken_q;
        written_d     = written_q;
        pack_d        = pack_q;
        tmo_cnt_d     = '0;
        tmo_flag_d    = tmo_flag_q;
        mem_addr_d    = mem_addr_q;
        dec_data_d    = dec_data_q;
        out_wen_d     = 1'b0;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;

        pack_ins = pack_q;
        pack_ins[{taken_q[2:0], 2'b00} +: 4] = dec_sym;

        capture = (state_q != S_IDLE) && (state_q != S_FIN) &&
                  dec_sym_valid && (taken_q < num_symbols_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_base_d     = rd_base;
                    num_words_d   = num_words;
                    num_symbols_d = num_symbols;
                    wr_base_d     = wr_base;
                    word_idx_d    = '0;
                    taken_d       = '0;
                    written_d     = '0;
                    pack_d        = '0;
                    tmo_flag_d    = 1'b0;
                    if (num_symbols == '0) begin
                        state_d = S_FIN;
                    end else if (num_words == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                dec_data_d = mem_q;
                state_d    = S_OFFER;
            end
            S_OFFER: begin
                if (dec_valid_q && dec_ready) begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    state_d    = (word_idx_d == num_words_q) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (!dec_sym_valid) begin
                    if (tmo_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d    = S_FLUSH;
                        tmo_flag_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TO_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            taken_d = taken_q + CNT_W'(1);
            if (taken_q[2:0] == 3'd7) begin
                out_wen_d  = 1'b1;
                out_data_d = pack_ins;
                out_addr_d = wr_base_q + written_q;
                written_d  = written_q + ADDR_W'(1);
                pack_d     = '0;
            end else begin
                pack_d = pack_ins;
            end
            if (taken_d == num_symbols_q && state_q != S_FLUSH) begin
                state_d = S_FLUSH;
            end
        end

        if (state_d == S_FLUSH && state_q != S_FLUSH && taken_d[2:0] != 3'd0) begin
            out_wen_d  = 1'b1;
            out_data_d = pack_d;
            out_addr_d = wr_base_q + written_d;
            written_d  = written_d + ADDR_W'(1);
            pack_d     = '0;
        end

        mem_cen_d = (state_d != S_FETCH);
        if (state_d == S_FETCH) begin
            mem_addr_d = rd_base_d + word_idx_d;
        end
        dec_valid_d = (state_d == S_OFFER);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        err_d       = (state_d == S_FIN) && tmo_flag_d;
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_base_q     <= '0;
            num_words_q   <= '0;
            num_symbols_q <= '0;
            wr_base_q     <= '0;
            word_idx_q    <= '0;
            taken_q       <= '0;
            written_q     <= '0;
            pack_q        <= '0;
            tmo_cnt_q     <= '0;
            tmo_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            mem_cen_q     <= 1'b1;
            mem_addr_q    <= '0;
            dec_data_q    <= '0;
            dec_valid_q   <= 1'b0;
            out_wen_q     <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_base_q     <= rd_base_d;
            num_words_q   <= num_words_d;
            num_symbols_q <= num_symbols_d;
            wr_base_q     <= wr_base_d;
            word_idx_q    <= word_idx_d;
            taken_q       <= taken_d;
            written_q     <= written_d;
            pack_q        <= pack_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tmo_flag_q    <= tmo_flag_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            mem_cen_q     <= mem_cen_d;
            mem_addr_q    <= mem_addr_d;
            dec_data_q    <= dec_data_d;
            dec_valid_q   <= dec_valid_d;
            out_wen_q     <= out_wen_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_cen   = mem_cen_q;
    assign mem_addr  = mem_addr_q;
    assign dec_data  = dec_data_q;
    assign dec_valid = dec_valid_q;
    assign out_wen   = out_wen_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule
